sdpram_burst_reader: RTL and testbench

Read-side engine for the simple dual-port line/test RAMs. It accepts a burst command (start address, word count), drives the RAM read address port while tracking the RAM's fixed read latency, and presents the returned words as a valid/ready stream with a last flag. A small credit-managed FIFO absorbs in-flight words, so downstream backpressure never drops data. The block sits between the RAM read port and the video/processing datapath; the writer side fills the RAM independently.

---
 rtl/sdpram_burst_reader_pkg.sv | 20 ++
 rtl/sdpram_burst_reader_if.sv | 28 ++
 rtl/sdpram_burst_reader_fifo.sv | 43 ++++
 rtl/sdpram_burst_reader.sv | 112 +++++++++++
 tb/tb_sdpram_burst_reader.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/sdpram_burst_reader_pkg.sv
// Shared types and latency constants for the SDP RAM burst reader.
// Build option: SDPRAM_RD_OUTPUT_REG_EN selects a RAM with an output register (RD_LAT=2).
package sdpram_rd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } state_t;

`ifdef SDPRAM_RD_OUTPUT_REG_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif

  // In-flight words plus one pop/push overlap must fit without stalling the issue side.
  localparam int FIFO_DEPTH_MIN = RD_LAT + 2;

endpackage

// File: rtl/sdpram_burst_reader_if.sv
// Command, RAM read-port and output-stream signals of the burst reader.
interface sdpram_burst_reader_if #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32
);
  logic                  cmd_valid;
  logic                  cmd_ready;
  logic [ADDR_WIDTH-1:0] cmd_addr;
  logic [ADDR_WIDTH:0]   cmd_len;
  logic [ADDR_WIDTH-1:0] ram_rd_addr;
  logic [DATA_WIDTH-1:0] ram_rd_data;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;
  logic                  busy;
  logic                  done;

  modport slave (
    input  cmd_valid, cmd_addr, cmd_len, ram_rd_data, m_ready,
    output cmd_ready, ram_rd_addr, m_valid, m_data, m_last, busy, done
  );

  modport master (
    output cmd_valid, cmd_addr, cmd_len, ram_rd_data, m_ready,
    input  cmd_ready, ram_rd_addr, m_valid, m_data, m_last, busy, done
  );
endinterface

// File: rtl/sdpram_burst_reader_fifo.sv
// Show-ahead synchronous FIFO that absorbs words returning from the RAM.
module sdpram_rd_fifo #(
  parameter int DW    = 32,
  parameter int DEPTH = 4
) (
  input  logic                     rd_clk,
  input  logic                     rd_rst_n,
  input  logic                     push,
  input  logic [DW-1:0]            push_data,
  input  logic                     pop,
  output logic [DW-1:0]            head,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [DEPTH-1:0][DW-1:0] mem;
  logic [AW-1:0]            wr_ptr, rd_ptr;

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Empty FIFO presents zero so the stream data is clean outside valid beats.
  assign head = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/sdpram_burst_reader.sv
// Burst read engine: issues RAM addresses under credit control, tracks RAM latency,
// streams words out with a last flag. Build option: SDPRAM_RD_OUTPUT_REG_EN.
module sdpram_burst_reader
  import sdpram_rd_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 32,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 rd_clk,
  input  logic                 rd_rst_n,
  sdpram_burst_reader_if.slave bus
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int LW = ADDR_WIDTH + 1;

  if (FIFO_DEPTH < FIFO_DEPTH_MIN || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two and at least RD_LAT+2");
  end

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [LW-1:0]         remaining, len_q, beat_cnt;
  logic [CW-1:0]         outstanding, fifo_cnt;
  logic [RD_LAT:1]       vld_pipe;
  logic [DATA_WIDTH-1:0] fifo_head;
  logic                  done_q, done_nxt;
  logic                  m_valid, m_last, pop, credit, issue, cmd_fire;

  assign m_valid  = (fifo_cnt != '0);
  assign pop      = m_valid && bus.m_ready;
  assign credit   = (outstanding < CW'(FIFO_DEPTH)) || pop;
  assign issue    = (state == ISSUE) && credit;
  assign cmd_fire = bus.cmd_valid && (state == IDLE);
  assign m_last   = m_valid && (beat_cnt == len_q - LW'(1));

  always_comb begin
    state_nxt = state;
    done_nxt  = 1'b0;
    case (state)
      IDLE: if (cmd_fire) begin
        if (bus.cmd_len != '0) state_nxt = ISSUE;
        else                   done_nxt  = 1'b1;
      end
      ISSUE: if (issue && remaining == LW'(1)) state_nxt = DRAIN;
      DRAIN: if (pop && m_last) begin
        state_nxt = IDLE;
        done_nxt  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      state  <= IDLE;
      done_q <= 1'b0;
    end else begin
      state  <= state_nxt;
      done_q <= done_nxt;
    end
  end

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      addr_q      <= '0;
      remaining   <= '0;
      len_q       <= '0;
      beat_cnt    <= '0;
      outstanding <= '0;
      vld_pipe    <= '0;
    end else begin
      if (cmd_fire) begin
        addr_q    <= bus.cmd_addr;
        remaining <= bus.cmd_len;
        len_q     <= bus.cmd_len;
      end else if (issue) begin
        addr_q    <= addr_q + ADDR_WIDTH'(1);
        remaining <= remaining - LW'(1);
      end
      if (cmd_fire) beat_cnt <= '0;
      else if (pop) beat_cnt <= beat_cnt + LW'(1);
      case ({issue, pop})
        2'b10:   outstanding <= outstanding + CW'(1);
        2'b01:   outstanding <= outstanding - CW'(1);
        default: outstanding <= outstanding;
      endcase
      // Valid bit rides alongside the RAM's read latency; its tail marks returning data.
      vld_pipe[1] <= issue;
      for (int i = 2; i <= RD_LAT; i++) vld_pipe[i] <= vld_pipe[i-1];
    end
  end

  sdpram_rd_fifo #(.DW(DATA_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
    .rd_clk   (rd_clk),
    .rd_rst_n (rd_rst_n),
    .push     (vld_pipe[RD_LAT]),
    .push_data(bus.ram_rd_data),
    .pop      (pop),
    .head     (fifo_head),
    .count    (fifo_cnt)
  );

  assign bus.cmd_ready   = (state == IDLE);
  assign bus.ram_rd_addr = addr_q;
  assign bus.m_valid     = m_valid;
  assign bus.m_data      = fifo_head;
  assign bus.m_last      = m_last;
  assign bus.busy        = (state != IDLE);
  assign bus.done        = done_q;

endmodule

// File: tb/tb_sdpram_burst_reader.sv
// Directed bench for sdpram_burst_reader: RAM model, expected-beat queue, per-cycle stream checks.
module tb_sdpram_burst_reader;
  import sdpram_rd_pkg::*;

  localparam int AW = 8;
  localparam int DW = 32;
  localparam int FD = 4;

  logic rd_clk = 1'b0;
  logic rd_rst_n = 1'b0;

  sdpram_burst_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus();

  sdpram_burst_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .FIFO_DEPTH(FD)) dut (
    .rd_clk  (rd_clk),
    .rd_rst_n(rd_rst_n),
    .bus     (bus)
  );

  always #5 rd_clk = ~rd_clk;

  // RAM read port: registered read plus optional output register.
  logic [DW-1:0] ram   [2**AW];
  logic [DW-1:0] ram_q [RD_LAT];
  always @(posedge rd_clk) begin
    ram_q[0] <= ram[bus.ram_rd_addr];
    for (int i = 1; i < RD_LAT; i++) ram_q[i] <= ram_q[i-1];
  end
  assign bus.ram_rd_data = ram_q[RD_LAT-1];

  int n_cmp = 0, n_err = 0;
  int cyc = 0;
  always @(posedge rd_clk) cyc <= cyc + 1;

  logic [DW-1:0] exp_q[$];
  bit            last_q[$];
  logic [DW-1:0] got_q[$];
  int  e_cyc, first_cyc, last_cyc, beat_n, rdy_mode, bp_start, bp_t;
  bit  seen_first, bubble_chk, prev_stall, prev_done;
  logic [DW-1:0] prev_data, ed;
  logic          prev_last;
  bit            el;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic check_reset();
    check("rst_cmd_ready", bus.cmd_ready, 1);
    check("rst_ram_addr", bus.ram_rd_addr, 0);
    check("rst_m_valid", bus.m_valid, 0);
    check("rst_m_data", bus.m_data, 0);
    check("rst_m_last", bus.m_last, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
  endtask

  // Downstream ready: always high, or toggle 10 cycles then hold low 10 cycles.
  initial begin
    bus.m_ready = 1'b0;
    forever begin
      @(posedge rd_clk);
      #1;
      if (rdy_mode == 0) bus.m_ready = 1'b1;
      else begin
        bp_t = cyc - bp_start;
        if (bp_t < 10)      bus.m_ready = (bp_t % 2 == 0);
        else if (bp_t < 20) bus.m_ready = 1'b0;
        else                bus.m_ready = 1'b1;
      end
    end
  end

  // Stream checker against the expected-beat queue.
  initial begin
    forever begin
      @(negedge rd_clk);
      if (!rd_rst_n) begin
        prev_stall = 0;
        prev_done  = 0;
      end else begin
        if (prev_stall) begin
          check("hold_valid", bus.m_valid, 1);
          check("hold_data", bus.m_data, prev_data);
          check("hold_last", bus.m_last, prev_last);
        end
        if (bus.m_valid && !seen_first) begin
          seen_first = 1;
          first_cyc  = cyc;
          check("first_latency", cyc - e_cyc, 2 + RD_LAT);
        end
        if (bubble_chk && seen_first && exp_q.size() > 0 && bus.m_ready)
          check("no_bubble", bus.m_valid, 1);
        if (bus.m_valid && bus.m_ready) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL extra_beat: got %0h expected no beat", bus.m_data);
          end else begin
            ed = exp_q.pop_front();
            el = last_q.pop_front();
            check("beat_data", bus.m_data, ed);
            check("beat_last", bus.m_last, el);
            got_q.push_back(bus.m_data);
            beat_n++;
            if (bus.m_last) last_cyc = cyc;
          end
        end
        if (bus.done) check("done_busy_low", bus.busy, 0);
        if (prev_done) check("done_one_cycle", bus.done, 0);
        prev_done  = bus.done;
        prev_stall = bus.m_valid && !bus.m_ready;
        prev_data  = bus.m_data;
        prev_last  = bus.m_last;
      end
    end
  end

  task automatic start_burst(input logic [AW-1:0] a, input logic [AW:0] len);
    @(negedge rd_clk);
    for (int i = 0; i < int'(len); i++) begin
      exp_q.push_back(ram[(int'(a) + i) % (2**AW)]);
      last_q.push_back(i == int'(len) - 1);
    end
    seen_first = 0;
    got_q.delete();
    beat_n = 0;
    e_cyc  = cyc;
    bus.cmd_valid = 1'b1;
    bus.cmd_addr  = a;
    bus.cmd_len   = len;
    check("cmd_ready_idle", bus.cmd_ready, 1);
    @(posedge rd_clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound, input bit nonzero);
    int k;
    k = 0;
    while (1) begin
      @(negedge rd_clk);
      if (bus.done) break;
      k++;
      if (k >= bound) begin
        n_cmp++;
        n_err++;
        $display("FAIL done_timeout: got no done expected done within %0d cycles", bound);
        return;
      end
    end
    if (nonzero) check("done_after_last", cyc, last_cyc + 1);
    else         check("done_zero_len", cyc, e_cyc + 1);
    check("all_beats_seen", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish by 200000");
    $fatal(1);
  end

  initial begin
    for (int i = 0; i < 2**AW; i++) ram[i] = DW'(i);
    bus.cmd_valid = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_len   = '0;
    rdy_mode = 0; bp_start = 0; bubble_chk = 1;
    seen_first = 1; beat_n = 0; e_cyc = 0; last_cyc = 0;

    #12;
    check_reset();
    @(posedge rd_clk); #2; rd_rst_n = 1'b1;

    // Single burst
    start_burst(8'h10, 9'd4);
    wait_done(50, 1);
    check("single_n", got_q.size(), 4);
    check("single_0", got_q[0], 32'h10);
    check("single_1", got_q[1], 32'h11);
    check("single_2", got_q[2], 32'h12);
    check("single_3", got_q[3], 32'h13);
    check("single_lat", first_cyc - e_cyc, (RD_LAT == 1) ? 3 : 4);

    // Wrap-around
    start_burst(8'hFE, 9'd4);
    wait_done(50, 1);
    check("wrap_0", got_q[0], 32'hFE);
    check("wrap_1", got_q[1], 32'hFF);
    check("wrap_2", got_q[2], 32'h00);
    check("wrap_3", got_q[3], 32'h01);

    // Backpressure
    bubble_chk = 0;
    bp_start = cyc;
    rdy_mode = 1;
    start_burst(8'h20, 9'd16);
    wait_done(300, 1);
    rdy_mode = 0;
    check("bp_n", got_q.size(), 16);
    check("bp_first", got_q[0], 32'h20);
    check("bp_last", got_q[15], 32'h2F);
    repeat (2) @(negedge rd_clk);

    // Zero length
    bubble_chk = 1;
    start_burst(8'h33, 9'd0);
    wait_done(10, 0);
    repeat (5) @(negedge rd_clk);
    check("zero_no_beats", got_q.size(), 0);

    // Full address space
    start_burst(8'h38, 9'd256);
    wait_done(400, 1);
    check("full_n", got_q.size(), 256);
    check("full_first", got_q[0], 32'h38);
    check("full_last", got_q[255], 32'h37);

    // Reset mid-burst
    start_burst(8'h40, 9'd8);
    for (int k = 0; k < 50 && beat_n < 3; k++) begin
      @(posedge rd_clk); #2;
    end
    check("mid_beats_before_rst", beat_n, 3);
    rd_rst_n = 1'b0;
    #1;
    check_reset();
    exp_q.delete();
    last_q.delete();
    repeat (2) @(posedge rd_clk);
    #2; rd_rst_n = 1'b1;
    start_burst(8'h80, 9'd2);
    wait_done(50, 1);
    repeat (6) @(negedge rd_clk);
    check("post_rst_n", got_q.size(), 2);
    check("post_rst_0", got_q[0], 32'h80);
    check("post_rst_1", got_q[1], 32'h81);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
